// File: rtl/axi4_slave_w_router.sv
// Per-slave AXI4 W-channel router: queues {master, AWLEN} in AW-acceptance order and
// steers exactly AWLEN+1 beats from the queued master, regenerating WLAST locally.
module axi4_slave_w_router #(
    parameter int unsigned MASTER_NUM  = 4,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned W_BUF_DEPTH = 2,
    parameter int unsigned MIDX_W      = $clog2(MASTER_NUM)
) (
    input  logic                             ACLK,
    input  logic                             ARESETn,
    input  logic                             aw_push_valid,
    input  logic [MIDX_W-1:0]                aw_push_midx,
    input  logic [7:0]                       aw_push_len,
    output logic                             aw_push_ready,
    input  logic [MASTER_NUM*DATA_WIDTH-1:0] m_wdata,
    input  logic [MASTER_NUM*DATA_WIDTH/8-1:0] m_wstrb,
    input  logic [MASTER_NUM-1:0]            m_wlast,
    input  logic [MASTER_NUM-1:0]            m_wvalid,
    output logic [MASTER_NUM-1:0]            m_wready,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    output logic [DATA_WIDTH/8-1:0]          s_wstrb,
    output logic                             s_wlast,
    output logic                             s_wvalid,
    input  logic                             s_wready,
    output logic                             wlast_err
);

    localparam int unsigned IDX_W  = $clog2(W_BUF_DEPTH);
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [MIDX_W-1:0] fifo_midx_q [W_BUF_DEPTH];
    logic [7:0]        fifo_len_q  [W_BUF_DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              wlast_err_q, wlast_err_d;

    logic              full, empty, head_valid, is_last;
    logic              push, pop, beat, sel_wlast;
    logic [MIDX_W-1:0] head_midx;
    logic [7:0]        head_len;

    // Extra wrap bit distinguishes full from empty when indices match
    assign full       = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) && (wptr_q[IDX_W] != rptr_q[IDX_W]);
    assign empty      = (wptr_q == rptr_q);
    assign head_valid = !empty;
    assign head_midx  = fifo_midx_q[rptr_q[IDX_W-1:0]];
    assign head_len   = fifo_len_q[rptr_q[IDX_W-1:0]];
    assign is_last    = (cnt_q == head_len);

    assign aw_push_ready = !full;
    assign s_wlast       = head_valid && is_last;
    assign wlast_err     = wlast_err_q;

    // Steer the head master's W channel to the slave
    always_comb begin
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        m_wready  = '0;
        sel_wlast = 1'b0;
        for (int unsigned i = 0; i < MASTER_NUM; i++) begin
            if (head_valid && (head_midx == MIDX_W'(i))) begin
                s_wvalid    = m_wvalid[i];
                s_wdata     = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                s_wstrb     = m_wstrb[i*STRB_W +: STRB_W];
                m_wready[i] = s_wready;
                sel_wlast   = m_wlast[i];
            end
        end
    end

    assign beat = s_wvalid && s_wready;
    assign pop  = beat && is_last;
    assign push = aw_push_valid && !full;

    always_comb begin
        wptr_d      = wptr_q + PTR_W'(push);
        rptr_d      = rptr_q + PTR_W'(pop);
        cnt_d       = cnt_q;
        wlast_err_d = 1'b0;
        if (beat) begin
            cnt_d       = is_last ? 8'd0 : cnt_q + 8'd1;
            wlast_err_d = (sel_wlast != is_last);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            wlast_err_q <= 1'b0;
            for (int unsigned i = 0; i < W_BUF_DEPTH; i++) begin
                fifo_midx_q[i] <= '0;
                fifo_len_q[i]  <= '0;
            end
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            wlast_err_q <= wlast_err_d;
            if (push) begin
                fifo_midx_q[wptr_q[IDX_W-1:0]] <= aw_push_midx;
                fifo_len_q[wptr_q[IDX_W-1:0]]  <= aw_push_len;
            end
        end
    end

endmodule

// File: tb/tb_axi4_slave_w_router.sv
// Bench for axi4_slave_w_router: queue-based burst model checked every cycle,
// plus directed scenarios with hand-counted beat/WLAST/error totals.
module tb_axi4_slave_w_router;

    localparam int unsigned MN = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned MW = 2;

    logic              ACLK = 1'b0;
    logic              ARESETn;
    logic              aw_push_valid;
    logic [MW-1:0]     aw_push_midx;
    logic [7:0]        aw_push_len;
    logic              aw_push_ready;
    logic [MN*DW-1:0]  m_wdata;
    logic [MN*SW-1:0]  m_wstrb;
    logic [MN-1:0]     m_wlast;
    logic [MN-1:0]     m_wvalid;
    logic [MN-1:0]     m_wready;
    logic [DW-1:0]     s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic              s_wlast;
    logic              s_wvalid;
    logic              s_wready;
    logic              wlast_err;

    axi4_slave_w_router #(
        .MASTER_NUM(MN), .DATA_WIDTH(DW), .W_BUF_DEPTH(DEPTH), .MIDX_W(MW)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .aw_push_valid(aw_push_valid), .aw_push_midx(aw_push_midx),
        .aw_push_len(aw_push_len), .aw_push_ready(aw_push_ready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .wlast_err(wlast_err)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [MW-1:0] midx;
        logic [7:0]    len;
    } ent_t;

    ent_t mq[$];
    int   mcnt;
    logic merr;
    int   checks = 0;
    int   failures = 0;
    int   beats = 0;
    int   wlasts = 0;
    int   errs = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: bursts are a queue; the head's master owns the slave until len+1 beats pass
    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            mq.delete();
            mcnt = 0;
            merr = 1'b0;
        end else begin
            int  sz;
            logic bt;
            logic lastb;
            sz = mq.size();
            merr = 1'b0;
            if (sz > 0) begin
                bt    = m_wvalid[mq[0].midx] && s_wready;
                lastb = (mcnt == int'(mq[0].len));
                if (bt) begin
                    merr = (m_wlast[mq[0].midx] != lastb);
                    if (lastb) begin
                        void'(mq.pop_front());
                        mcnt = 0;
                    end else begin
                        mcnt++;
                    end
                end
            end
            if (aw_push_valid && sz < DEPTH)
                mq.push_back('{midx: aw_push_midx, len: aw_push_len});
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge ACLK) begin
        logic          hv;
        int            sel;
        logic [DW-1:0] e_data;
        logic [SW-1:0] e_strb;
        logic [MN-1:0] e_mr;
        logic          e_last;
        hv = (mq.size() != 0);
        sel = hv ? int'(mq[0].midx) : 0;
        e_data = hv ? m_wdata[sel*DW +: DW] : '0;
        e_strb = hv ? m_wstrb[sel*SW +: SW] : '0;
        e_mr = (hv && s_wready) ? MN'(1 << sel) : '0;
        e_last = hv && (mcnt == int'(mq[0].len));
        chk("aw_push_ready", 64'(aw_push_ready), 64'(mq.size() < DEPTH));
        chk("s_wvalid", 64'(s_wvalid), 64'(hv && m_wvalid[sel]));
        chk("s_wlast", 64'(s_wlast), 64'(e_last));
        chk("s_wdata", s_wdata, e_data);
        chk("s_wstrb", 64'(s_wstrb), 64'(e_strb));
        chk("m_wready", 64'(m_wready), 64'(e_mr));
        chk("wlast_err", 64'(wlast_err), 64'(merr));
        if (s_wvalid && s_wready && ARESETn) begin
            beats++;
            if (s_wlast) wlasts++;
        end
        if (wlast_err) errs++;
    end

    task automatic step();
        @(posedge ACLK);
        #1;
        cyc++;
        for (int i = 0; i < MN; i++) begin
            m_wdata[i*DW +: DW] = {32'(cyc), 32'(i)};
            m_wstrb[i*SW +: SW] = SW'(cyc * 4 + i);
        end
    endtask

    task automatic push(input int midx, input int len);
        aw_push_valid = 1'b1;
        aw_push_midx  = MW'(midx);
        aw_push_len   = 8'(len);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    int b0, l0, e0;

    initial begin
        ARESETn = 1'b0;
        aw_push_valid = 1'b0;
        aw_push_midx = '0;
        aw_push_len = '0;
        m_wdata = '0;
        m_wstrb = '0;
        m_wlast = '0;
        m_wvalid = '0;
        s_wready = 1'b0;
        run(2);
        chk("reset_ready", 64'(aw_push_ready), 64'd1);
        chk("reset_svalid", 64'(s_wvalid), 64'd0);
        ARESETn = 1'b1;
        step();

        // Single burst: master 2, 4 beats
        b0 = beats; l0 = wlasts;
        m_wvalid = 4'b0100; s_wready = 1'b1;
        push(2, 3);
        step();
        aw_push_valid = 1'b0;
        run(6);
        chk("t1_beats", 64'(beats - b0), 64'd4);
        chk("t1_wlasts", 64'(wlasts - l0), 64'd1);
        m_wvalid = '0;

        // Ordering: master 3 waits behind master 1
        b0 = beats; l0 = wlasts;
        m_wvalid = 4'b1000;
        push(1, 0);
        step();
        push(3, 1);
        step();
        aw_push_valid = 1'b0;
        run(3);
        chk("t2_stall", 64'(beats - b0), 64'd0);
        m_wvalid = 4'b1010;
        run(5);
        chk("t2_beats", 64'(beats - b0), 64'd3);
        chk("t2_wlasts", 64'(wlasts - l0), 64'd2);
        m_wvalid = '0;

        // Full: two entries with slave stalled, third push ignored
        b0 = beats;
        s_wready = 1'b0;
        push(0, 1);
        step();
        push(1, 0);
        step();
        chk("t3_full", 64'(aw_push_ready), 64'd0);
        push(2, 0);
        step();
        aw_push_valid = 1'b0;
        m_wvalid = 4'b0111;
        s_wready = 1'b1;
        run(6);
        chk("t3_beats", 64'(beats - b0), 64'd3);
        m_wvalid = '0;

        // Back-to-back single-beat bursts with push and pop on the same edge, past wrap
        b0 = beats;
        m_wvalid = 4'b1111;
        push(0, 0);
        step();
        for (int k = 1; k < 7; k++) begin
            push(k % 4, 0);
            step();
        end
        aw_push_valid = 1'b0;
        run(3);
        chk("t4_beats", 64'(beats - b0), 64'd7);
        m_wvalid = '0;

        // WLAST mismatch: master holds WLAST from beat 0
        b0 = beats; l0 = wlasts; e0 = errs;
        m_wvalid = 4'b0010;
        m_wlast = 4'b0010;
        push(1, 1);
        step();
        aw_push_valid = 1'b0;
        run(4);
        chk("t5_errs", 64'(errs - e0), 64'd1);
        chk("t5_beats", 64'(beats - b0), 64'd2);
        chk("t5_wlasts", 64'(wlasts - l0), 64'd1);
        m_wvalid = '0;
        m_wlast = '0;

        // Reset mid-burst
        m_wvalid = 4'b1000;
        push(3, 3);
        step();
        aw_push_valid = 1'b0;
        step();
        ARESETn = 1'b0;
        #1;
        chk("t6_rst_svalid", 64'(s_wvalid), 64'd0);
        chk("t6_rst_ready", 64'(aw_push_ready), 64'd1);
        step();
        ARESETn = 1'b1;
        step();
        b0 = beats; l0 = wlasts;
        push(3, 1);
        step();
        aw_push_valid = 1'b0;
        run(4);
        chk("t6_beats", 64'(beats - b0), 64'd2);
        chk("t6_wlasts", 64'(wlasts - l0), 64'd1);
        m_wvalid = '0;
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
